// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types and constants for the load/store unit
// Purpose: FSM state encoding, funct3 access-size codes and the request
//          legality check used by load_store_unit.
// Ports:   none (package).
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 1 when the request must be refused without touching memory.
  function automatic logic lsu_illegal(input logic rd, input logic wr,
                                       input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    bad = rd & wr;
    case (f3)
      F3_B, F3_BU: ;
      F3_H, F3_HU: if (off[0]) bad = 1'b1;
      F3_W:        if (off != 2'b00) bad = 1'b1;
      default:     bad = 1'b1;
    endcase
    // unsigned sizes only make sense for loads
    if (wr && (f3 == F3_BU || f3 == F3_HU)) bad = 1'b1;
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - data-memory request/acknowledge bus
// Purpose: groups the req/ack handshake to data memory.
// Ports:   dm_req/dm_we/dm_addr/dm_be/dm_wdata driven by the LSU (master),
//          dm_ack/dm_rdata driven by memory (slave).
interface load_store_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_be;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (output dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  input  dm_ack, dm_rdata);
  modport slave  (input  dm_req, dm_we, dm_addr, dm_be, dm_wdata,
                  output dm_ack, dm_rdata);
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-lane steering for stores and load extraction
// Purpose: combinational store byte-enable/replication and load
//          byte/half selection with sign or zero extension.
// Ports:   st_funct3/st_off/st_we/st_data -> st_be/st_lanes (store side),
//          ld_funct3/ld_off/ld_word -> ld_data (load side).
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3,
  input  logic [1:0]  st_off,
  input  logic        st_we,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_lanes,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_off,
  input  logic [31:0] ld_word,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_lanes = '0;
    if (st_we) begin
      case (st_funct3)
        F3_B: begin
          st_be    = 4'b0001 << st_off;
          st_lanes = {4{st_data[7:0]}};
        end
        F3_H: begin
          st_be    = st_off[1] ? 4'b1100 : 4'b0011;
          st_lanes = {2{st_data[15:0]}};
        end
        default: st_lanes = st_data;
      endcase
    end
  end

  always_comb begin
    ld_byte = ld_word[{ld_off, 3'b000} +: 8];
    ld_half = ld_word[{ld_off[1], 4'b0000} +: 16];
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_data = {{16{ld_half[15]}}, ld_half};
      F3_BU:   ld_data = {24'd0, ld_byte};
      F3_HU:   ld_data = {16'd0, ld_half};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory access stage with stall and timeout
// Purpose: accepts a load/store from the ALU stage, runs one req/ack access
//          on the data bus, extends load data and stalls the core meanwhile.
// Ports:   clk, rst (async active-low); mem_read/mem_write/funct3/addr/wdata
//          request; rdata/stall/done/misalign/bus_err status; dm bus master.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  load_store_unit_if.master dm
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  lsu_state_e  state, next_state;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  be_q;
  logic        op, bad, accept, tmo;
  logic [3:0]  st_be;
  logic [31:0] st_lanes, ld_data;

  lsu_align u_align (
    .st_funct3 (funct3),
    .st_off    (addr[1:0]),
    .st_we     (mem_write),
    .st_data   (wdata),
    .st_be     (st_be),
    .st_lanes  (st_lanes),
    .ld_funct3 (f3_q),
    .ld_off    (off_q),
    .ld_word   (dm.dm_rdata),
    .ld_data   (ld_data)
  );

  always_comb begin
    op         = mem_read | mem_write;
    bad        = lsu_illegal(mem_read, mem_write, funct3, addr[1:0]);
    accept     = (state == IDLE) && op && !bad;
    tmo        = (cnt == TMO_LAST);
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = BUSY;
      BUSY:    if (dm.dm_ack || tmo) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
    // gated by rst so a reset mid-access releases the core immediately
    stall = rst && (accept || state == BUSY);
  end

  assign done        = (state == DONE);
  assign dm.dm_req   = (state == BUSY);
  assign dm.dm_we    = we_q;
  assign dm.dm_addr  = addr_q;
  assign dm.dm_be    = be_q;
  assign dm.dm_wdata = wdata_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      f3_q     <= '0;
      off_q    <= '0;
      addr_q   <= '0;
      be_q     <= '0;
      wdata_q  <= '0;
      rdata    <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= next_state;
      misalign <= (state == IDLE) && op && bad;
      bus_err  <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          we_q    <= mem_write;
          f3_q    <= funct3;
          off_q   <= addr[1:0];
          addr_q  <= {addr[31:2], 2'b00};
          be_q    <= st_be;
          wdata_q <= st_lanes;
          cnt     <= '0;
        end
        BUSY: begin
          // ack takes priority over a simultaneous timeout
          if (dm.dm_ack) begin
            rdata <= we_q ? 32'd0 : ld_data;
          end else if (tmo) begin
            rdata   <= '0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;
  import lsu_pkg::*;

  typedef struct packed {
    logic [31:0] rdata;
    logic        berr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, rdata;
  logic        stall, done, misalign, bus_err;
  int          vec = 0;
  int          err = 0;
  exp_t        sb[$];

  load_store_unit_if dm ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .stall     (stall),
    .done      (done),
    .misalign  (misalign),
    .bus_err   (bus_err),
    .dm        (dm)
  );

  always #5 clk = ~clk;

  // Drives one request and plays memory; records what the bus and status showed.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd,
                            input int waits, input logic ack_en, input logic [31:0] mrd,
                            output int stall_cyc, output int done_cyc, output int busy_cyc,
                            output logic [31:0] o_addr, output logic [31:0] o_wdata,
                            output logic [3:0] o_be, output logic o_we,
                            output logic [31:0] o_rdata, output logic o_berr,
                            output logic got_done);
    stall_cyc = 0; done_cyc = 0; busy_cyc = 0; got_done = 1'b0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0; o_rdata = '0; o_berr = 1'b0;
    @(negedge clk);
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = wd;
    for (int c = 0; c < 40 && !got_done; c++) begin
      dm.dm_ack = 1'b0;
      #1;
      if (done) begin
        got_done = 1'b1; done_cyc = c + 1;
        o_rdata = rdata; o_berr = bus_err;
        mem_read = 1'b0; mem_write = 1'b0;
      end else begin
        if (stall) stall_cyc++;
        if (dm.dm_req) begin
          o_addr = dm.dm_addr; o_wdata = dm.dm_wdata; o_be = dm.dm_be; o_we = dm.dm_we;
          if (ack_en && busy_cyc == waits) begin
            dm.dm_ack = 1'b1; dm.dm_rdata = mrd;
          end
          busy_cyc++;
        end
        @(negedge clk);
      end
    end
    mem_read = 1'b0; mem_write = 1'b0; dm.dm_ack = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #12;
    vec++; if ({dm.dm_req, done, misalign, bus_err, dm.dm_we, stall} !== 6'b0) begin
      err++; $display("FAIL reset_flags: got %b want 000000", {dm.dm_req, done, misalign, bus_err, dm.dm_we, stall}); end
    vec++; if (rdata !== 32'd0) begin err++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    vec++; if ({dm.dm_addr, dm.dm_be, dm.dm_wdata} !== 68'd0) begin
      err++; $display("FAIL reset_bus: got %h %h %h want 0", dm.dm_addr, dm.dm_be, dm.dm_wdata); end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_store_word;
    int sc, dc, bc; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, obe, gd; exp_t e;
    sb.push_back('{rdata: 32'd0, berr: 1'b0});
    run_access(1'b0, 1'b1, F3_W, 32'h100, 32'hDEADBEEF, 0, 1'b1, 32'h0,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    e = sb.pop_front();
    vec++; if (gd !== 1'b1) begin err++; $display("FAIL sw_done_seen: got %b want 1", gd); end
    vec++; if (oa !== 32'h100) begin err++; $display("FAIL sw_addr: got %h want 00000100", oa); end
    vec++; if (ob !== 4'b1111) begin err++; $display("FAIL sw_be: got %b want 1111", ob); end
    vec++; if (ow !== 32'hDEADBEEF) begin err++; $display("FAIL sw_wdata: got %h want deadbeef", ow); end
    vec++; if (owe !== 1'b1) begin err++; $display("FAIL sw_we: got %b want 1", owe); end
    vec++; if (sc !== 2) begin err++; $display("FAIL sw_stall_cycles: got %0d want 2", sc); end
    vec++; if (dc !== 3) begin err++; $display("FAIL sw_done_cycle: got %0d want 3", dc); end
    vec++; if ({ord, obe} !== {e.rdata, e.berr}) begin
      err++; $display("FAIL sw_result: got %h/%b want %h/%b", ord, obe, e.rdata, e.berr); end
  endtask

  task automatic test_load_byte;
    logic [2:0]  f3s [3] = '{F3_B, F3_BU, F3_B};
    logic [31:0] as  [3] = '{32'h103, 32'h103, 32'h100};
    logic [31:0] exs [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFFCC};
    int sc, dc, bc; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, obe, gd; exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{rdata: exs[i], berr: 1'b0});
      run_access(1'b1, 1'b0, f3s[i], as[i], 32'hFFFF_FFFF, 0, 1'b1, 32'h80AABBCC,
                 sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
      e = sb.pop_front();
      vec++; if ({ord, obe} !== {e.rdata, e.berr}) begin
        err++; $display("FAIL lb_result[%0d]: got %h/%b want %h/%b", i, ord, obe, e.rdata, e.berr); end
      if (i == 0) begin
        vec++; if ({oa, ob, ow, owe} !== {32'h100, 4'b1111, 32'h0, 1'b0}) begin
          err++; $display("FAIL lb_bus: got %h %b %h %b want 00000100 1111 0 0", oa, ob, ow, owe); end
      end
    end
  endtask

  task automatic test_half;
    int sc, dc, bc; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, obe, gd; exp_t e;
    run_access(1'b0, 1'b1, F3_H, 32'h102, 32'hAAAA1234, 0, 1'b1, 32'h0,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    vec++; if ({oa, ob, ow} !== {32'h100, 4'b1100, 32'h12341234}) begin
      err++; $display("FAIL sh_bus: got %h %b %h want 00000100 1100 12341234", oa, ob, ow); end
    run_access(1'b0, 1'b1, F3_B, 32'h101, 32'h000000A5, 0, 1'b1, 32'h0,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    vec++; if ({ob, ow} !== {4'b0010, 32'hA5A5A5A5}) begin
      err++; $display("FAIL sb_bus: got %b %h want 0010 a5a5a5a5", ob, ow); end
    sb.push_back('{rdata: 32'hFFFF8001, berr: 1'b0});
    run_access(1'b1, 1'b0, F3_H, 32'h102, 32'h0, 0, 1'b1, 32'h8001BEEF,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    e = sb.pop_front();
    vec++; if (ord !== e.rdata) begin err++; $display("FAIL lh_rdata: got %h want %h", ord, e.rdata); end
    sb.push_back('{rdata: 32'h00008001, berr: 1'b0});
    run_access(1'b1, 1'b0, F3_HU, 32'h102, 32'h0, 0, 1'b1, 32'h8001BEEF,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    e = sb.pop_front();
    vec++; if (ord !== e.rdata) begin err++; $display("FAIL lhu_rdata: got %h want %h", ord, e.rdata); end
    // two wait states: stall spans IDLE plus three BUSY cycles
    sb.push_back('{rdata: 32'h13579BDF, berr: 1'b0});
    run_access(1'b1, 1'b0, F3_W, 32'h108, 32'h0, 2, 1'b1, 32'h13579BDF,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    e = sb.pop_front();
    vec++; if ({ord, obe} !== {e.rdata, e.berr}) begin
      err++; $display("FAIL lw_wait_result: got %h/%b want %h/%b", ord, obe, e.rdata, e.berr); end
    vec++; if (sc !== 4 || dc !== 5) begin
      err++; $display("FAIL lw_wait_timing: got stall %0d done %0d want 4 5", sc, dc); end
  endtask

  task automatic test_misalign;
    logic        mr  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic        mw  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [2:0]  f3s [5] = '{F3_W, F3_H, 3'b011, F3_BU, F3_W};
    logic [31:0] as  [5] = '{32'h101, 32'h103, 32'h100, 32'h100, 32'h100};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_read = mr[i]; mem_write = mw[i]; funct3 = f3s[i]; addr = as[i]; wdata = 32'h55;
      #1;
      vec++; if (stall !== 1'b0) begin err++; $display("FAIL mis_stall[%0d]: got %b want 0", i, stall); end
      @(negedge clk);
      mem_read = 1'b0; mem_write = 1'b0;
      #1;
      vec++; if ({misalign, dm.dm_req} !== 2'b10) begin
        err++; $display("FAIL mis_pulse[%0d]: got misalign %b req %b want 1 0", i, misalign, dm.dm_req); end
      @(negedge clk);
      #1;
      vec++; if ({misalign, dm.dm_req, done} !== 3'b000) begin
        err++; $display("FAIL mis_clear[%0d]: got %b want 000", i, {misalign, dm.dm_req, done}); end
    end
  endtask

  task automatic test_timeout;
    int sc, dc, bc; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, obe, gd; exp_t e;
    // ack lands in the last allowed BUSY cycle and must beat the timeout
    sb.push_back('{rdata: 32'hCAFEF00D, berr: 1'b0});
    run_access(1'b1, 1'b0, F3_W, 32'h204, 32'h0, 3, 1'b1, 32'hCAFEF00D,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    e = sb.pop_front();
    vec++; if ({ord, obe} !== {e.rdata, e.berr}) begin
      err++; $display("FAIL ack_wins: got %h/%b want %h/%b", ord, obe, e.rdata, e.berr); end
    sb.push_back('{rdata: 32'd0, berr: 1'b1});
    run_access(1'b1, 1'b0, F3_W, 32'h200, 32'h0, 0, 1'b0, 32'h0,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    e = sb.pop_front();
    vec++; if (gd !== 1'b1) begin err++; $display("FAIL tmo_done_seen: got %b want 1", gd); end
    vec++; if ({ord, obe} !== {e.rdata, e.berr}) begin
      err++; $display("FAIL tmo_result: got %h/%b want %h/%b", ord, obe, e.rdata, e.berr); end
    vec++; if (bc !== 4) begin err++; $display("FAIL tmo_busy_cycles: got %0d want 4", bc); end
    @(negedge clk);
    dm.dm_ack = 1'b1; dm.dm_rdata = 32'h12345678;
    @(negedge clk);
    dm.dm_ack = 1'b0;
    #1;
    vec++; if ({done, dm.dm_req, stall, bus_err} !== 4'b0 || rdata !== 32'd0) begin
      err++; $display("FAIL late_ack: got %b rdata %h want 0000 rdata 0", {done, dm.dm_req, stall, bus_err}, rdata); end
  endtask

  task automatic test_reset_busy;
    int sc, dc, bc; logic [31:0] oa, ow, ord; logic [3:0] ob; logic owe, obe, gd; exp_t e;
    @(negedge clk);
    mem_read = 1'b1; funct3 = F3_W; addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    #1;
    vec++; if (dm.dm_req !== 1'b1) begin err++; $display("FAIL rstb_req_before: got %b want 1", dm.dm_req); end
    #2;
    rst = 1'b0;
    #1;
    vec++; if ({dm.dm_req, stall, done} !== 3'b000) begin
      err++; $display("FAIL rstb_async: got %b want 000", {dm.dm_req, stall, done}); end
    vec++; if (rdata !== 32'd0) begin err++; $display("FAIL rstb_rdata: got %h want 0", rdata); end
    mem_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    sb.push_back('{rdata: 32'd0, berr: 1'b0});
    run_access(1'b0, 1'b1, F3_W, 32'h104, 32'h0BADF00D, 0, 1'b1, 32'h0,
               sc, dc, bc, oa, ow, ob, owe, ord, obe, gd);
    e = sb.pop_front();
    vec++; if ({oa, ob, ow, owe} !== {32'h104, 4'b1111, 32'h0BADF00D, 1'b1}) begin
      err++; $display("FAIL rstb_sw_bus: got %h %b %h %b", oa, ob, ow, owe); end
    vec++; if ({ord, obe} !== {e.rdata, e.berr} || dc !== 3) begin
      err++; $display("FAIL rstb_sw_done: got %h/%b cyc %0d want %h/%b cyc 3", ord, obe, dc, e.rdata, e.berr); end
  endtask

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; funct3 = '0; addr = '0; wdata = '0;
    dm.dm_ack = 1'b0; dm.dm_rdata = '0;
    test_reset();
    test_store_word();
    test_load_byte();
    test_half();
    test_misalign();
    test_timeout();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Data-memory access stage directly downstream of the ALU. Takes the ALU Result as the effective address, plus rs2 store data and funct3 from the decoder. It generates byte-lane enables and replicated store data, runs a req/ack handshake to data memory, and sign/zero-extends load data for writeback. While an access is in flight it stalls the core (PC/regfile write hold) and reports misalignment and bus timeouts.

Parameters:
TIMEOUT, 16, max BUSY cycles without dm_ack before the access is abandoned (range 1..255)

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
mem_read  in  1  load request from control unit
mem_write  in  1  store request from control unit
funct3  in  3  access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
addr  in  32  effective address (ALU Result)
wdata  in  32  store data (rs2)
rdata  out  32  extended load data to writeback mux
stall  out  1  hold PC and regfile write
done  out  1  one-cycle pulse, access complete
misalign  out  1  one-cycle pulse, illegal/misaligned request, no access made
bus_err  out  1  valid with done, access timed out
dm_req  out  1  memory request, held until ack
dm_we  out  1  1 = write
dm_addr  out  32  word-aligned address {addr[31:2],2'b00}
dm_be  out  4  byte enables
dm_wdata  out  32  lane-replicated store data
dm_ack  in  1  memory completion, single-cycle pulse
dm_rdata  in  32  read word, valid with dm_ack

Behaviour:
- Reset (rst=0, async): state IDLE; rdata, done, misalign, bus_err, dm_req, dm_we, dm_be, dm_addr, dm_wdata, timeout counter all 0. Reset during BUSY drops dm_req immediately; the pending access is discarded.
- FSM states: IDLE, BUSY, DONE.
- IDLE, op = mem_read|mem_write:
  - If legal, latch addr/funct3/we/wdata lanes and go BUSY.
  - stall is combinationally 1 in that IDLE cycle.
- Illegal request, checked in IDLE:
  - Conditions: mem_read&mem_write; funct3 in {011,110,111}; funct3 in {001,101} with addr[0]=1; funct3=010 with addr[1:0]!=0; any store with funct3 in {100,101}.
  - Response: misalign=1 for one registered cycle, stall=0, no dm_req, stay IDLE.
- BUSY:
  - dm_req=1 with registered dm_we/dm_addr/dm_be/dm_wdata held stable. stall=1.
  - Counter increments each cycle without dm_ack.
  - dm_ack seen: go DONE, register rdata (loads only).
  - Counter reaches TIMEOUT: go DONE with bus_err=1, rdata=0.
  - dm_ack and timeout in the same cycle: ack wins.
- DONE: dm_req=0, done=1, stall=0 (PC advances this edge), return to IDLE. Requests presented in DONE are ignored. The next instruction is sampled in IDLE.
- dm_ack outside BUSY is ignored.
- Latency: zero-wait memory gives IDLE→BUSY→DONE, 3 cycles, stall high 2 cycles. Each wait cycle adds 1.
- Store lanes, o = addr[1:0]:
  - SB: be = 4'b0001<<o, dm_wdata = {4{wdata[7:0]}}.
  - SH: be = addr[1]?4'b1100:4'b0011, dm_wdata = {2{wdata[15:0]}}.
  - SW: be = 4'b1111, dm_wdata = wdata.
  - Loads: be = 4'b1111, dm_wdata = 0.
- Load extraction:
  - Byte = dm_rdata[8*o+:8]; half = dm_rdata[16*addr[1]+:16].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
  - Stores leave rdata = 0.
- rdata holds its value until the next DONE or reset.

Decomposition:
- Shared package lsu_pkg holds:
  - state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
- One combinational sub-module, lsu_align, holds the byte-enable/store-replication logic and the load extract/extend logic. The top level keeps the FSM, timeout counter and registers.

Test Plan:
1. SW addr=0x100 wdata=0xDEADBEEF, ack in first BUSY cycle → dm_addr=0x100, dm_be=1111, dm_wdata=0xDEADBEEF, dm_we=1; stall high 2 cycles; done on cycle 3.
2. LB addr=0x103, dm_rdata=0x80AABBCC → rdata=0xFFFFFF80. LBU same → 0x00000080. LB addr=0x100 → 0xFFFFFFCC.
3. SH addr=0x102 wdata=0xAAAA1234 → dm_be=1100, dm_wdata=0x12341234. LH addr=0x102, dm_rdata=0x8001BEEF → 0xFFFF8001. LHU → 0x00008001.
4. LW addr=0x101 → misalign pulse 1 cycle, dm_req stays 0, stall=0. SH addr=0x103 → same. funct3=011 load → same.
5. TIMEOUT=4, LW addr=0x200, no ack → 4 BUSY cycles, then DONE with bus_err=1, rdata=0. A late dm_ack arriving in IDLE is ignored.
6. rst driven low in the 2nd BUSY cycle of a 3-wait-state read → dm_req=0 and stall=0 without waiting for a clock edge. After release, a new SW completes normally.
